alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/cpu_pkg.sv | 44 ++++
 rtl/alu_issue_regfile.sv | 36 +++
 rtl/alu_issue.sv | 180 ++++++++++++++++++
 tb/tb_alu_issue.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the alu_issue slice.
// Holds the issue FSM state type, the ALU opcode constants, the bit positions
// of the instruction fields, and small helpers for sign extension and
// carry-out generation.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    localparam logic [4:0] OP_ADD   = 5'b10000;
    localparam logic [4:0] OP_ADC   = 5'b10001;
    localparam logic [4:0] OP_SUB   = 5'b10010;
    localparam logic [4:0] OP_LOGIC = 5'b10011;

    localparam int OP_MSB    = 15;
    localparam int OP_LSB    = 11;
    localparam int CLASS_BIT = 15;
    localparam int RA_MSB    = 4;
    localparam int RA_LSB    = 3;
    localparam int RB_MSB    = 1;
    localparam int RB_LSB    = 0;
    localparam int IMM6_SEL  = 5;

    function automatic logic [15:0] sext6(input logic [5:0] v);
        return {{10{v[5]}}, v};
    endfunction

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

    // Carry out of a + b + cin, computed as an overflow compare so that no
    // partially-used sum vector is left behind.
    function automatic logic add_carry(input logic [15:0] a, input logic [15:0] b,
                                       input logic cin);
        return ({1'b0, a} + {1'b0, b} + {16'd0, cin}) > 17'h0FFFF;
    endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// alu_issue_regfile: 4 x 16 architectural register file.
// Ports:
//   clk, rst_n            clock, synchronous active-low clear of all entries
//   i_raddr_a/o_rdata_a   combinational read port A
//   i_raddr_b/o_rdata_b   combinational read port B
//   i_we/i_waddr/i_wdata  synchronous write port
module alu_issue_regfile
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  i_raddr_a,
    output logic [15:0] o_rdata_a,
    input  logic [1:0]  i_raddr_b,
    output logic [15:0] o_rdata_b,
    input  logic        i_we,
    input  logic [1:0]  i_waddr,
    input  logic [15:0] i_wdata
);

    logic [15:0] r_mem [4];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/alu_issue.sv
// alu_issue: single-issue fetch / execute / writeback sequencer feeding an
// external combinational ALU.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   run                        start pulse, only looked at in IDLE
//   imem_req/imem_addr         instruction fetch request and address (= pc)
//   imem_ack/imem_rdata        fetch acknowledge and instruction word
//   instruction, regA, regA_imm6, regA_imm8, regB, carry
//                              operand bus to the ALU, live in EXEC, held otherwise
//   result                     ALU result, captured at the end of EXEC
//   pc, halted                 architectural status
//   retired                    retired-instruction counter (only with
//                              ALU_ISSUE_RETIRE_CNT_EN defined)
//
// state | meaning
// IDLE  | waiting for run
// FETCH | imem_req raised, waiting for imem_ack
// EXEC  | operand bus live, result and carry captured at end of cycle
// WB    | register write for ALU class, pc + 1
// HALT  | instruction 0x0000 seen, only reset leaves
module alu_issue
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instruction,
    output logic [15:0] regA,
    output logic [15:0] regA_imm6,
    output logic [15:0] regA_imm8,
    output logic [15:0] regB,
    output logic        carry,
    input  logic [15:0] result,
    output logic [15:0] pc,
`ifdef ALU_ISSUE_RETIRE_CNT_EN
    output logic [15:0] retired,
`endif
    output logic        halted
);

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_pc;
    logic [15:0] r_instr;
    logic [15:0] r_result;
    logic        r_carry;

    logic [15:0] r_op_instr;
    logic [15:0] r_op_ra;
    logic [15:0] r_op_rb;
    logic [15:0] r_op_imm6;
    logic [15:0] r_op_imm8;
    logic        r_op_carry;

    logic [15:0] w_rdata_a;
    logic [15:0] w_rdata_b;
    logic [15:0] w_imm6;
    logic [15:0] w_imm8;
    logic [15:0] w_operand;
    logic [4:0]  w_opcode;
    logic        w_is_add;
    logic        w_is_adc;
    logic        w_in_exec;
    logic        w_rf_we;

    always_comb begin
        w_next_state = r_state;
        imem_req     = 1'b0;
        halted       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (run) w_next_state = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) w_next_state = ST_EXEC;
            end
            ST_EXEC: begin
                w_next_state = (r_instr == 16'h0000) ? ST_HALT : ST_WB;
            end
            ST_WB: begin
                w_next_state = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_in_exec = (r_state == ST_EXEC);
    assign w_opcode  = r_instr[OP_MSB:OP_LSB];
    assign w_is_add  = (w_opcode == OP_ADD);
    assign w_is_adc  = (w_opcode == OP_ADC);
    assign w_imm6    = sext6(r_instr[5:0]);
    assign w_imm8    = sext8(r_instr[7:0]);
    assign w_operand = r_instr[IMM6_SEL] ? w_imm6 : w_rdata_b;
    assign w_rf_we   = (r_state == ST_WB) && r_instr[CLASS_BIT];

    alu_issue_regfile u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_raddr_a (r_instr[RA_MSB:RA_LSB]),
        .o_rdata_a (w_rdata_a),
        .i_raddr_b (r_instr[RB_MSB:RB_LSB]),
        .o_rdata_b (w_rdata_b),
        .i_we      (w_rf_we),
        .i_waddr   (r_instr[RA_MSB:RA_LSB]),
        .i_wdata   (r_result)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_op_instr <= '0;
            r_op_ra    <= '0;
            r_op_rb    <= '0;
            r_op_imm6  <= '0;
            r_op_imm8  <= '0;
            r_op_carry <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == ST_FETCH) && imem_ack) begin
                r_instr <= imem_rdata;
            end
            if (w_in_exec) begin
                r_result   <= result;
                // Snapshot of the live bus so the outputs hold after EXEC.
                r_op_instr <= r_instr;
                r_op_ra    <= w_rdata_a;
                r_op_rb    <= w_rdata_b;
                r_op_imm6  <= w_imm6;
                r_op_imm8  <= w_imm8;
                r_op_carry <= r_carry;
                if (w_is_add || w_is_adc) begin
                    r_carry <= add_carry(w_rdata_a, w_operand, w_is_adc & r_carry);
                end
            end
            if (r_state == ST_WB) begin
                r_pc <= r_pc + 16'd1;
            end
        end
    end

    assign instruction = w_in_exec ? r_instr   : r_op_instr;
    assign regA        = w_in_exec ? w_rdata_a : r_op_ra;
    assign regB        = w_in_exec ? w_rdata_b : r_op_rb;
    assign regA_imm6   = w_in_exec ? w_imm6    : r_op_imm6;
    assign regA_imm8   = w_in_exec ? w_imm8    : r_op_imm8;
    assign carry       = w_in_exec ? r_carry   : r_op_carry;
    assign imem_addr   = r_pc;
    assign pc          = r_pc;

`ifdef ALU_ISSUE_RETIRE_CNT_EN
    logic [15:0] r_retired;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_retired <= '0;
        end else if (r_state == ST_WB) begin
            r_retired <= r_retired + 16'd1;
        end
    end

    assign retired = r_retired;
`endif

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

    localparam logic [15:0] RPC = 16'hFFFC;

    logic        clk = 1'b0;
    logic        rst_n, run, imem_ack;
    logic [15:0] imem_rdata, result;
    logic        imem_req, carry, halted;
    logic [15:0] imem_addr, instruction, regA, regA_imm6, regA_imm8, regB, pc;
`ifdef ALU_ISSUE_RETIRE_CNT_EN
    logic [15:0] retired;
`endif

    always #5 clk = ~clk;

    alu_issue #(.RESET_PC(RPC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .regA        (regA),
        .regA_imm6   (regA_imm6),
        .regA_imm8   (regA_imm8),
        .regB        (regB),
        .carry       (carry),
        .result      (result),
        .pc          (pc),
`ifdef ALU_ISSUE_RETIRE_CNT_EN
        .retired     (retired),
`endif
        .halted      (halted)
    );

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    // Architectural model: registers, carry, pc, expected handshake/status,
    // and the operand bus as last presented in EXEC.
    logic [15:0] m_R [4];
    logic        m_carry;
    logic [15:0] m_pc, m_retired;
    logic        e_req, e_halt;
    logic [15:0] b_instr, b_ra, b_rb, b_i6, b_i8;
    logic        b_c;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc", pc, m_pc);
            chk("imem_req", {15'd0, imem_req}, {15'd0, e_req});
            if (e_req) chk("imem_addr", imem_addr, m_pc);
            chk("halted", {15'd0, halted}, {15'd0, e_halt});
            chk("instruction", instruction, b_instr);
            chk("regA", regA, b_ra);
            chk("regB", regB, b_rb);
            chk("regA_imm6", regA_imm6, b_i6);
            chk("regA_imm8", regA_imm8, b_i8);
            chk("carry", {15'd0, carry}, {15'd0, b_c});
`ifdef ALU_ISSUE_RETIRE_CNT_EN
            chk("retired", retired, m_retired);
`endif
        end
    end

    function automatic logic [15:0] sx(input int v, input int bits);
        int s;
        s = v;
        if (v >= (1 << (bits - 1))) s = v - (1 << bits);
        return 16'(s);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        run        = 1'($urandom);
        imem_ack   = 1'($urandom);
        imem_rdata = 16'($urandom);
        step();
        for (int i = 0; i < 4; i++) m_R[i] = 16'h0000;
        m_carry   = 1'b0;
        m_pc      = RPC;
        m_retired = 16'h0000;
        e_req     = 1'b0;
        e_halt    = 1'b0;
        b_instr = 0; b_ra = 0; b_rb = 0; b_i6 = 0; b_i8 = 0; b_c = 1'b0;
        chk_en    = 1'b1;
        rst_n     = 1'b1;
        run       = 1'b0;
        imem_ack  = 1'b0;
    endtask

    task automatic start_run();
        run = 1'b1;
        step();
        run   = 1'b0;
        e_req = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            imem_ack   = 1'($urandom);
            imem_rdata = 16'($urandom);
            step();
        end
        imem_ack = 1'b0;
    endtask

    // Entered in a FETCH cycle; leaves in the next FETCH cycle, or in HALT.
    task automatic do_instr(input logic [15:0] ins, input int waits, input logic [15:0] res);
        int ra, rb, sum, cin;
        logic [15:0] opnd;
        logic new_c;
        ra = int'(ins[4:3]);
        rb = int'(ins[1:0]);
        for (int i = 0; i < waits; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = 16'($urandom);
            step();
        end
        imem_ack   = 1'b1;
        imem_rdata = ins;
        step();
        // EXEC
        imem_ack   = 1'($urandom);
        imem_rdata = 16'($urandom);
        result     = res;
        e_req      = 1'b0;
        b_instr = ins;
        b_ra    = m_R[ra];
        b_rb    = m_R[rb];
        b_i6    = sx(int'(ins[5:0]), 6);
        b_i8    = sx(int'(ins[7:0]), 8);
        b_c     = m_carry;
        new_c   = m_carry;
        if (ins[15:11] == 5'b10000 || ins[15:11] == 5'b10001) begin
            opnd  = ins[5] ? b_i6 : m_R[rb];
            cin   = (ins[15:11] == 5'b10001 && m_carry) ? 1 : 0;
            sum   = int'(m_R[ra]) + int'(opnd) + cin;
            new_c = (sum > 65535);
        end
        step();
        imem_ack = 1'($urandom);
        result   = 16'($urandom);
        m_carry  = new_c;
        if (ins == 16'h0000) begin
            e_halt   = 1'b1;
            imem_ack = 1'b0;
            return;
        end
        // WB
        step();
        imem_ack = 1'b0;
        if (ins[15]) m_R[ra] = res;
        m_pc = m_pc + 16'd1;
        m_retired = m_retired + 16'd1;
        e_req = 1'b1;
    endtask

    // Entered in FETCH; reset hits with the request outstanding, then a late ack.
    task automatic fetch_reset(input int waits);
        for (int i = 0; i < waits; i++) begin
            imem_ack = 1'b0;
            step();
        end
        do_reset();
        imem_ack   = 1'b1;
        imem_rdata = 16'h8000;
        step();
        imem_ack = 1'b0;
    endtask

    function automatic logic [15:0] rand_ins();
        logic [15:0] v;
        int sel;
        v   = 16'($urandom);
        sel = $urandom_range(0, 9);
        case (sel)
            0, 1: v[15:11] = 5'b10000;
            2, 3: v[15:11] = 5'b10001;
            4:    v[15:11] = 5'b10010;
            5:    v[15:11] = 5'b10011;
            6:    v[15] = 1'b1;
            7:    v[15] = 1'b0;
            default: ;
        endcase
        if (v == 16'h0000) v = 16'h0001;
        return v;
    endfunction

    logic [15:0] pc_save;

    initial begin
        rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0; result = 16'h0;
        step();
        do_reset();
        chk("lit_reset_pc", pc, 16'hFFFC);
        chk("lit_reset_req", {15'd0, imem_req}, 16'h0000);
        idle_cycles(3);
        start_run();

        // R1=5, R0=10, then ADD R0,R1 with ALU result 15
        do_instr(16'h8009, 0, 16'd5);
        do_instr(16'h8000, 0, 16'd10);
        do_instr(16'h8001, 0, 16'd15);
        chk("lit_add_regA", regA, 16'd10);
        chk("lit_add_regB", regB, 16'd5);
        chk("lit_add_carry", {15'd0, carry}, 16'h0000);
        chk("lit_pc_ffff", pc, 16'hFFFF);
        // NOP at pc 0xFFFF wraps pc
        do_instr(16'h1234, 0, 16'hDEAD);
        chk("lit_pc_wrap", pc, 16'h0000);
        do_instr(16'h8000, 0, 16'h0015);
        chk("lit_r0_after_wb", regA, 16'd15);

        // two fetch wait cycles
        do_instr(16'h9000, 2, 16'h1234);

        // carry generation then ADC consumption
        do_instr(16'h8000, 0, 16'hFFFF);
        do_instr(16'h8009, 0, 16'h0001);
        do_instr(16'h8001, 1, 16'h0000);
        do_instr(16'h9008, 0, 16'h0000);
        do_instr(16'h8801, 0, 16'h0001);
        chk("lit_adc_carry_in", {15'd0, carry}, 16'h0001);
        chk("lit_adc_regA", regA, 16'h0000);
        chk("lit_adc_regB", regB, 16'h0000);

        for (int n = 0; n < 300; n++) begin
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 3) begin
                do_instr(16'h0000, $urandom_range(0, 2), 16'($urandom));
                idle_cycles(4);
                do_reset();
                start_run();
            end else if (sel < 6) begin
                fetch_reset($urandom_range(0, 2));
                idle_cycles(2);
                start_run();
            end else begin
                do_instr(rand_ins(), $urandom_range(0, 3), 16'($urandom));
            end
        end

        // halt: run and ack ignored until reset
        pc_save = m_pc;
        do_instr(16'h0000, 1, 16'h5555);
        chk("lit_halted", {15'd0, halted}, 16'h0001);
        for (int i = 0; i < 5; i++) begin
            run = 1'b1;
            imem_ack = 1'b1;
            imem_rdata = 16'h8000;
            step();
        end
        run = 1'b0;
        imem_ack = 1'b0;
        chk("lit_halt_pc", pc, pc_save);
        do_reset();
        chk("lit_halt_cleared", {15'd0, halted}, 16'h0000);

        // reset mid-FETCH followed by a late ack
        start_run();
        do_instr(16'h8008, 0, 16'h00AA);
        fetch_reset(1);
        chk("lit_rst_pc", pc, 16'hFFFC);
        chk("lit_rst_req", {15'd0, imem_req}, 16'h0000);
        idle_cycles(2);
        start_run();
        do_instr(16'h8008, 0, 16'h0001);
        chk("lit_rst_no_write", regA, 16'h0000);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
